// File: rtl/stack_seq64_pkg.sv
// stack_seq64_pkg: state encoding, error codes and stack bounds for the 64-bit stack sequencer
package stack_seq64_pkg;
    localparam logic [31:0] SP_TOP_DEF = 32'h3FF;
    localparam logic [31:0] SP_FLOOR_DEF = 32'h200;
    typedef enum logic [2:0] {S_IDLE, S_PSH_HI, S_PSH_LO, S_POP_LO, S_POP_HI, S_DONE} state_t;
    typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_OVF = 2'b01, ERR_UNF = 2'b10, ERR_TMO = 2'b11} err_t;
endpackage

// File: rtl/stack_seq64_if.sv
// stack_seq64_if: 32-bit word memory beat bus between the sequencer and the memory port
interface stack_seq64_if #(parameter int ADDR_W = 32);
    logic req;
    logic we;
    logic ack;
    logic [ADDR_W-1:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master(output req, we, addr, wdata, input rdata, ack);
    modport slave(input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/stack_seq64_beat_timer.sv
// stack_seq64_beat_timer: counts cycles a memory beat waits for ack and flags expiry
module stack_seq64_beat_timer #(parameter int TIMEOUT = 16) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
    // The first waiting cycle sees cnt=0, so TIMEOUT-1 marks the last allowed cycle
    assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/stack_seq64.sv
// stack_seq64: moves 64-bit operands to/from a 32-bit word stack as two beats,
// steering the external SP register and reporting overflow, underflow and timeout.
module stack_seq64
    import stack_seq64_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [31:0] SP_TOP = SP_TOP_DEF,
    parameter logic [31:0] SP_FLOOR = SP_FLOOR_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_req,
    input  logic pop_req,
    input  logic [63:0] push_data,
    output logic [63:0] pop_data,
    output logic busy,
    output logic done,
    output logic [1:0] err,
    input  logic [31:0] sp_val,
    output logic sp_oe,
    output logic sp_inc,
    output logic sp_dec,
    stack_seq64_if.master mem
);
    state_t state;
    logic [63:0] operand;
    logic beat, ack, expired, ovf, unf, rej;
    assign beat = state inside {S_PSH_HI, S_PSH_LO, S_POP_LO, S_POP_HI};
    assign ack = beat && mem.ack;
    assign ovf = sp_val < SP_FLOOR + 32'd2;
    assign unf = sp_val > SP_TOP - 32'd2;
    assign rej = push_req ? ovf : unf;
    assign sp_oe = state != S_IDLE || push_req || pop_req;
    // SP moves on the same edge as the state change so each beat addresses the updated SP
    assign sp_dec = (state == S_IDLE && push_req && !ovf) || (state == S_PSH_HI && ack);
    assign sp_inc = (state == S_POP_LO || state == S_POP_HI) && ack;
    assign mem.req = beat;
    assign mem.we = state == S_PSH_HI || state == S_PSH_LO;
    assign mem.addr = beat ? sp_val[ADDR_W-1:0] : '0;
    assign mem.wdata = state == S_PSH_HI ? operand[63:32] : state == S_PSH_LO ? operand[31:0] : '0;
    stack_seq64_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clr(!beat || ack),
        .en(beat && !ack),
        .expired(expired)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            err <= ERR_OK;
            operand <= '0;
            pop_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE:
                    if (push_req || pop_req) begin
                        err <= rej ? (push_req ? ERR_OVF : ERR_UNF) : ERR_OK;
                        done <= rej;
                        busy <= !rej;
                        state <= rej ? S_DONE : push_req ? S_PSH_HI : S_POP_LO;
                        if (push_req && !ovf) operand <= push_data;
                    end
                S_PSH_HI, S_PSH_LO, S_POP_LO, S_POP_HI:
                    if (ack) begin
                        if (state == S_POP_LO) pop_data[31:0] <= mem.rdata;
                        if (state == S_POP_HI) pop_data[63:32] <= mem.rdata;
                        done <= state == S_PSH_LO || state == S_POP_HI;
                        busy <= state == S_PSH_HI || state == S_POP_LO;
                        state <= state == S_PSH_HI ? S_PSH_LO : state == S_POP_LO ? S_POP_HI : S_DONE;
                    end else if (expired) begin
                        err <= ERR_TMO;
                        done <= 1'b1;
                        busy <= 1'b0;
                        state <= S_DONE;
                    end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_stack_seq64.sv
// tb_stack_seq64: directed stimulus with a scoreboard monitor for memory beats and done responses
module tb_stack_seq64;
    import stack_seq64_pkg::*;

    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} beat_t;
    typedef struct {logic [1:0] err; logic [63:0] pop; bit chk_pop; logic [31:0] sp;} resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic push_req = 1'b0, pop_req = 1'b0;
    logic [63:0] push_data = '0;
    logic [63:0] pop_data;
    logic busy, done, sp_oe, sp_inc, sp_dec;
    logic [1:0] err;
    logic [31:0] sp_val, sp_reg, sp_ld_val = '0;
    logic sp_ld = 1'b0, ack_en = 1'b1;
    logic [31:0] ram [0:1023];
    beat_t beat_q[$];
    resp_t resp_q[$];
    beat_t mb;
    resp_t mr;
    int n_chk = 0, n_fail = 0;

    stack_seq64_if #(.ADDR_W(32)) mem();

    stack_seq64 dut (
        .clk(clk), .rst_n(rst_n), .push_req(push_req), .pop_req(pop_req),
        .push_data(push_data), .pop_data(pop_data), .busy(busy), .done(done), .err(err),
        .sp_val(sp_val), .sp_oe(sp_oe), .sp_inc(sp_inc), .sp_dec(sp_dec), .mem(mem)
    );

    always #5 clk = ~clk;

    // External SP register model, reloadable like software would
    always @(posedge clk or negedge rst_n)
        if (!rst_n) sp_reg <= 32'h3FF;
        else if (sp_ld) sp_reg <= sp_ld_val;
        else if (sp_inc) sp_reg <= sp_reg + 32'd1;
        else if (sp_dec) sp_reg <= sp_reg - 32'd1;
    assign sp_val = sp_oe ? sp_reg : 32'h0;

    assign mem.ack = mem.req && ack_en;
    assign mem.rdata = ram[mem.addr[9:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (rst_n) begin
            chk("inc_dec_exclusive", 64'(sp_inc & sp_dec), 64'd0);
            if (mem.req && mem.ack) begin
                chk("beat_expected", 64'(beat_q.size() != 0), 64'd1);
                if (beat_q.size() != 0) begin
                    mb = beat_q.pop_front();
                    chk("beat_we", 64'(mem.we), 64'(mb.we));
                    chk("beat_addr", 64'(mem.addr), 64'(mb.addr));
                    if (mb.we) chk("beat_wdata", 64'(mem.wdata), 64'(mb.wdata));
                end
                if (mem.we) ram[mem.addr[9:0]] = mem.wdata;
            end
            if (done) begin
                chk("done_expected", 64'(resp_q.size() != 0), 64'd1);
                if (resp_q.size() != 0) begin
                    mr = resp_q.pop_front();
                    chk("done_err", 64'(err), 64'(mr.err));
                    chk("done_sp", 64'(sp_reg), 64'(mr.sp));
                    chk("done_busy", 64'(busy), 64'd0);
                    if (mr.chk_pop) chk("pop_data", pop_data, mr.pop);
                end
            end
        end

    task automatic exp_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        beat_t b;
        b.we = we; b.addr = addr; b.wdata = wdata;
        beat_q.push_back(b);
    endtask

    task automatic exp_resp(input logic [1:0] e, input logic [63:0] pop, input bit cp, input logic [31:0] sp);
        resp_t r;
        r.err = e; r.pop = pop; r.chk_pop = cp; r.sp = sp;
        resp_q.push_back(r);
    endtask

    task automatic sp_load(input logic [31:0] v);
        sp_ld = 1'b1; sp_ld_val = v;
        @(negedge clk);
        sp_ld = 1'b0;
    endtask

    // Issue one request at a negedge in IDLE and wait (bounded) for done
    task automatic op(input bit psh, input bit pp, input logic [63:0] d, input int lat);
        int n = 0;
        push_req = psh; pop_req = pp; push_data = d;
        @(posedge clk); #1;
        push_req = 1'b0; pop_req = 1'b0;
        do begin @(negedge clk); n++; end while (!done && n < 50);
        chk("done_seen", 64'(done), 64'd1);
        if (lat != 0) chk("done_latency", 64'(n), 64'(lat));
        @(negedge clk);
    endtask

    task automatic push_ok(input logic [63:0] d, input logic [31:0] sp, input bit both);
        exp_beat(1'b1, sp - 32'd1, d[63:32]);
        exp_beat(1'b1, sp - 32'd2, d[31:0]);
        exp_resp(ERR_OK, '0, 1'b0, sp - 32'd2);
        op(1'b1, both, d, 0);
    endtask

    task automatic pop_ok(input logic [63:0] d, input logic [31:0] sp);
        exp_beat(1'b0, sp, '0);
        exp_beat(1'b0, sp + 32'd1, '0);
        exp_resp(ERR_OK, d, 1'b1, sp + 32'd2);
        op(1'b0, 1'b1, '0, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_req", 64'(mem.req), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_sp", 64'(sp_reg), 64'h3FF);
        chk("rst_sp_oe", 64'(sp_oe), 64'd0);
        chk("rst_pop_data", pop_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        push_ok(64'h1122334455667788, 32'h3FF, 1'b0);
        pop_ok(64'h1122334455667788, 32'h3FD);
        push_ok(64'h0123456789ABCDEF, 32'h3FF, 1'b1);
        pop_ok(64'h0123456789ABCDEF, 32'h3FD);

        exp_resp(ERR_UNF, '0, 1'b0, 32'h3FF);
        op(1'b0, 1'b1, '0, 1);
        sp_load(32'h3FE);
        exp_resp(ERR_UNF, '0, 1'b0, 32'h3FE);
        op(1'b0, 1'b1, '0, 1);
        sp_load(32'h201);
        exp_resp(ERR_OVF, '0, 1'b0, 32'h201);
        op(1'b1, 1'b0, 64'hFFFF0000FFFF0000, 1);
        sp_load(32'h202);
        push_ok(64'hA5A5A5A55A5A5A5A, 32'h202, 1'b0);
        pop_ok(64'hA5A5A5A55A5A5A5A, 32'h200);

        sp_load(32'h3FF);
        ack_en = 1'b0;
        exp_resp(ERR_TMO, '0, 1'b0, 32'h3FE);
        push_req = 1'b1; push_data = 64'hCAFEBABE00000001;
        @(posedge clk); #1;
        push_req = 1'b0;
        begin
            int run = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!mem.req) break;
                run++;
            end
            chk("tmo_req_cycles", 64'(run), 64'd16);
            chk("tmo_done", 64'(done), 64'd1);
        end
        @(negedge clk);
        ack_en = 1'b1;

        sp_load(32'h3FF);
        exp_beat(1'b1, 32'h3FE, 32'h0BADF00D);
        push_req = 1'b1; push_data = 64'h0BADF00D12345678;
        @(posedge clk); #1;
        push_req = 1'b0;
        @(posedge clk); #1;
        ack_en = 1'b0;
        @(negedge clk);
        chk("psh_lo_addr", 64'(mem.addr), 64'h3FD);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 64'(mem.req), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sp", 64'(sp_reg), 64'h3FF);
        @(negedge clk);
        rst_n = 1'b1; ack_en = 1'b1;
        @(negedge clk);
        push_ok(64'hDEADBEEFCAFEF00D, 32'h3FF, 1'b0);
        pop_ok(64'hDEADBEEFCAFEF00D, 32'h3FD);

        repeat (2) @(negedge clk);
        chk("beat_q_drained", 64'(beat_q.size()), 64'd0);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end
endmodule
